order_scheduler: RTL and testbench

ORDER_SCHEDULER -- requirements
Module: order_scheduler

---
 rtl/order_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_order_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/order_scheduler.sv
// order_scheduler
//   Round-robin scheduler that takes quantity requests from four requesters and
//   turns each one into a single buy or sell pulse for the order generator.
//   Consecutive issue pulses are spaced at least MIN_GAP cycles apart. The block
//   also keeps a running signed net position.
//
//   A request with qty = 0 is accepted and then dropped: req_ready and
//   order_reject pulse, and the FSM returns straight to IDLE without a GAP.
//
//   Optional feature: define ORDER_SCHED_RISK_LIMIT_EN to reject any order that
//   would take |position| above MAX_POS. With the macro undefined there is no
//   limit check.
//
// Parameters
//   MIN_GAP      minimum cycles between issue pulses (2..255)
//   MAX_POS      absolute net-position limit (risk build only)
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    [3:0]  per-requester request
//   req_side     [3:0]  per-requester side, 0 = buy, 1 = sell
//   req_qty      [63:0] per-requester qty, requester i on [16i+15:16i]
//   req_ready    [3:0]  one-cycle accept pulse to the granted requester
//   buy, sell           one-cycle command pulses
//   qty          [15:0] quantity for the command (holds outside ISSUE)
//   grant_id     [1:0]  requester served (holds outside ISSUE)
//   order_reject        one-cycle pulse when an accepted request is dropped
//   position     [31:0] signed net position
module order_scheduler #(
    parameter int unsigned MIN_GAP = 8,
    parameter int unsigned MAX_POS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [3:0]  req_side,
    input  logic [63:0] req_qty,
    output logic [3:0]  req_ready,
    output logic        buy,
    output logic        sell,
    output logic [15:0] qty,
    output logic [1:0]  grant_id,
    output logic        order_reject,
    output logic [31:0] position
);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    // GAP lasts MIN_GAP-2 cycles, so ISSUE + GAP + IDLE spans MIN_GAP cycles.
    localparam logic [7:0] GapLoad = 8'(MIN_GAP - 2);

    state_e      state_q, state_d;
    logic [1:0]  rr_ptr_q;
    logic [7:0]  gap_cnt_q;
    logic [1:0]  grant_q;
    logic        side_q;
    logic [15:0] qty_q;
    logic [31:0] pos_q;

    logic        win_found;
    logic [1:0]  win_idx;
    logic        risk_fail;
    logic        issue_ok;

    // Round-robin search from rr_ptr_q. Walking the offsets downwards lets the
    // smallest offset with a valid request win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req_valid[rr_ptr_q + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = rr_ptr_q + 2'(i);
            end
        end
    end

`ifdef ORDER_SCHED_RISK_LIMIT_EN
    logic signed [32:0] pos_next;
    logic        [32:0] pos_abs;

    // 33-bit arithmetic so the limit check itself cannot wrap.
    always_comb begin
        if (side_q) begin
            pos_next = $signed({pos_q[31], pos_q}) - $signed({17'b0, qty_q});
        end else begin
            pos_next = $signed({pos_q[31], pos_q}) + $signed({17'b0, qty_q});
        end
        pos_abs   = pos_next[32] ? 33'(-pos_next) : 33'(pos_next);
        risk_fail = (pos_abs > 33'(MAX_POS));
    end
`else
    assign risk_fail = 1'b0;

    logic unused_max_pos;
    assign unused_max_pos = ^32'(MAX_POS);
`endif

    assign issue_ok = (qty_q != 16'd0) && !risk_fail;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!issue_ok || (MIN_GAP <= 2)) begin
                    state_d = StIdle;
                end else begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q <= 8'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: pulses exist only in ISSUE
    always_comb begin
        req_ready    = 4'b0000;
        buy          = 1'b0;
        sell         = 1'b0;
        order_reject = 1'b0;
        if (state_q == StIssue) begin
            req_ready[grant_q] = 1'b1;
            buy                = issue_ok & ~side_q;
            sell               = issue_ok & side_q;
            order_reject       = ~issue_ok;
        end
    end

    // Datapath: request latch, round-robin pointer, gap counter, position
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= 2'd0;
            gap_cnt_q <= 8'd0;
            grant_q   <= 2'd0;
            side_q    <= 1'b0;
            qty_q     <= 16'd0;
            pos_q     <= 32'd0;
        end else begin
            if (state_q == StIdle && win_found) begin
                grant_q  <= win_idx;
                side_q   <= req_side[win_idx];
                qty_q    <= req_qty[16*win_idx +: 16];
                rr_ptr_q <= win_idx + 2'd1;
            end
            if (state_q == StIssue && issue_ok) begin
                gap_cnt_q <= GapLoad;
            end else if (state_q == StGap) begin
                gap_cnt_q <= gap_cnt_q - 8'd1;
            end
            if (buy) begin
                pos_q <= pos_q + {16'd0, qty_q};
            end else if (sell) begin
                pos_q <= pos_q - {16'd0, qty_q};
            end
        end
    end

    assign qty      = qty_q;
    assign grant_id = grant_q;
    assign position = pos_q;

endmodule

// File: tb/tb_order_scheduler.sv
// Directed testbench for order_scheduler. Instance u_dut uses MIN_GAP = 8,
// instance u_dut_b uses MIN_GAP = 2. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, away from the edge.
module tb_order_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_side;
    logic [63:0] req_qty;
    logic [3:0]  req_ready;
    logic        buy;
    logic        sell;
    logic [15:0] qty;
    logic [1:0]  grant_id;
    logic        order_reject;
    logic [31:0] position;

    logic        b_rst;
    logic [3:0]  b_req_valid;
    logic [3:0]  b_req_side;
    logic [63:0] b_req_qty;
    logic [3:0]  b_req_ready;
    logic        b_buy;
    logic        b_sell;
    logic [15:0] b_qty;
    logic [1:0]  b_grant_id;
    logic        b_order_reject;
    logic [31:0] b_position;

    order_scheduler #(.MIN_GAP(8), .MAX_POS(1000)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_side     (req_side),
        .req_qty      (req_qty),
        .req_ready    (req_ready),
        .buy          (buy),
        .sell         (sell),
        .qty          (qty),
        .grant_id     (grant_id),
        .order_reject (order_reject),
        .position     (position)
    );

    order_scheduler #(.MIN_GAP(2), .MAX_POS(1000)) u_dut_b (
        .clk          (clk),
        .rst          (b_rst),
        .req_valid    (b_req_valid),
        .req_side     (b_req_side),
        .req_qty      (b_req_qty),
        .req_ready    (b_req_ready),
        .buy          (b_buy),
        .sell         (b_sell),
        .qty          (b_qty),
        .grant_id     (b_grant_id),
        .order_reject (b_order_reject),
        .position     (b_position)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tick     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tick++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int last_tick;
        int n;

        rst         = 1'b1;
        req_valid   = 4'b0000;
        req_side    = 4'b0000;
        req_qty     = 64'd0;
        b_rst       = 1'b1;
        b_req_valid = 4'b0000;
        b_req_side  = 4'b0000;
        b_req_qty   = 64'd0;

        // Reset values, then one buy of 100 from requester 0
        do_reset();
        check_eq("rst_ready", 32'(req_ready), 32'h0);
        check_eq("rst_buy", 32'(buy), 32'h0);
        check_eq("rst_sell", 32'(sell), 32'h0);
        check_eq("rst_reject", 32'(order_reject), 32'h0);
        check_eq("rst_qty", 32'(qty), 32'h0);
        check_eq("rst_grant", 32'(grant_id), 32'h0);
        check_eq("rst_pos", position, 32'h0);

        req_valid = 4'b0001;
        req_side  = 4'b0000;
        req_qty   = 64'd100;
        step();
        check_eq("t1_buy", 32'(buy), 32'h1);
        check_eq("t1_sell", 32'(sell), 32'h0);
        check_eq("t1_qty", 32'(qty), 32'd100);
        check_eq("t1_grant", 32'(grant_id), 32'd0);
        check_eq("t1_ready", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        step();
        check_eq("t1_pos", position, 32'd100);
        check_eq("t1_buy_off", 32'(buy), 32'h0);

        // All four valid: grants 0,1,2,3,0 exactly 8 cycles apart
        do_reset();
        req_valid = 4'b1111;
        req_side  = 4'b0000;
        req_qty   = {16'd40, 16'd30, 16'd20, 16'd10};
        last_tick = 0;
        for (int p = 0; p < 5; p++) begin
            n = 0;
            step();
            while (!(buy | sell) && n < 20) begin
                step();
                n++;
            end
            check_eq("t2_seen", 32'(buy), 32'h1);
            check_eq("t2_grant", 32'(grant_id), 32'(p % 4));
            if (p > 0) begin
                check_eq("t2_spacing", 32'(tick - last_tick), 32'd8);
            end
            last_tick = tick;
        end
        req_valid = 4'b0000;
        step();
        check_eq("t2_pos", position, 32'd110);

        // Requester 2 sells qty 0 (dropped), requester 3 served 2 cycles later
        do_reset();
        req_valid = 4'b1100;
        req_side  = 4'b0100;
        req_qty   = {16'd7, 16'd0, 32'd0};
        step();
        check_eq("t3_ready", 32'(req_ready), 32'b0100);
        check_eq("t3_reject", 32'(order_reject), 32'h1);
        check_eq("t3_sell", 32'(sell), 32'h0);
        check_eq("t3_buy", 32'(buy), 32'h0);
        check_eq("t3_grant", 32'(grant_id), 32'd2);
        req_valid = 4'b1000;
        step();
        check_eq("t3_idle_ready", 32'(req_ready), 32'h0);
        check_eq("t3_idle_reject", 32'(order_reject), 32'h0);
        step();
        check_eq("t3_next_buy", 32'(buy), 32'h1);
        check_eq("t3_next_grant", 32'(grant_id), 32'd3);
        check_eq("t3_next_qty", 32'(qty), 32'd7);
        check_eq("t3_next_ready", 32'(req_ready), 32'b1000);
        req_valid = 4'b0000;
        step();
        check_eq("t3_pos", position, 32'd7);

        // Buy 600 then 500; the second waits through GAP
        do_reset();
        req_valid = 4'b0001;
        req_side  = 4'b0000;
        req_qty   = 64'd600;
        step();
        check_eq("t4_buy1", 32'(buy), 32'h1);
        req_qty = 64'd500;
        for (int k = 0; k < 7; k++) begin
            step();
        end
        check_eq("t4_wait_ready", 32'(req_ready), 32'h0);
        check_eq("t4_qty_hold", 32'(qty), 32'd600);
        check_eq("t4_pos1", position, 32'd600);
        step();
`ifdef ORDER_SCHED_RISK_LIMIT_EN
        check_eq("t4_reject2", 32'(order_reject), 32'h1);
        check_eq("t4_buy2", 32'(buy), 32'h0);
`else
        check_eq("t4_reject2", 32'(order_reject), 32'h0);
        check_eq("t4_buy2", 32'(buy), 32'h1);
`endif
        check_eq("t4_ready2", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        step();
`ifdef ORDER_SCHED_RISK_LIMIT_EN
        check_eq("t4_pos2", position, 32'd600);
`else
        check_eq("t4_pos2", position, 32'd1100);
`endif

        // Reset during GAP with requests held; pointer restarts at 0
        do_reset();
        req_valid = 4'b0001;
        req_side  = 4'b0000;
        req_qty   = 64'd5;
        step();
        check_eq("t5_buy", 32'(buy), 32'h1);
        req_valid = 4'b0011;
        req_qty   = {32'd0, 16'd9, 16'd5};
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5_rst_ready", 32'(req_ready), 32'h0);
        check_eq("t5_rst_buy", 32'(buy), 32'h0);
        check_eq("t5_rst_sell", 32'(sell), 32'h0);
        check_eq("t5_rst_reject", 32'(order_reject), 32'h0);
        check_eq("t5_rst_qty", 32'(qty), 32'h0);
        check_eq("t5_rst_grant", 32'(grant_id), 32'h0);
        check_eq("t5_rst_pos", position, 32'h0);
        step();
        check_eq("t5_re_buy", 32'(buy), 32'h1);
        check_eq("t5_re_grant", 32'(grant_id), 32'd0);
        check_eq("t5_re_qty", 32'(qty), 32'd5);
        check_eq("t5_re_ready", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        step();

        // MIN_GAP = 2: requester 1 sells 5 continuously, pulse every 2 cycles
        b_rst       = 1'b0;
        b_req_valid = 4'b0010;
        b_req_side  = 4'b0010;
        b_req_qty   = {32'd0, 16'd5, 16'd0};
        for (int k = 1; k <= 6; k++) begin
            step();
            check_eq("t6_sell", 32'(b_sell), 32'(k % 2));
            check_eq("t6_pos", b_position, 32'(-5 * (k / 2)));
        end
        check_eq("t6_grant", 32'(b_grant_id), 32'd1);
        b_req_valid = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
